// File: rtl/voice_mixer.sv
// Sequential multi-voice mixer: per-voice gain MAC, master volume scale, output fit.
// Optional build macro VOICE_MIXER_SATURATE_EN clamps the output instead of wrapping.
module voice_mixer #(
    parameter int NUM_VOICES  = 4,
    parameter int DATA_BITS   = 12,
    parameter int GAIN_BITS   = 4,
    parameter int OUTPUT_BITS = 12
) (
    input  logic                                main_clk,
    input  logic                                rst,
    input  logic                                sample_tick,
    input  logic [NUM_VOICES*DATA_BITS-1:0]     voice_data,
    input  logic [NUM_VOICES*GAIN_BITS-1:0]     voice_gain,
    input  logic [7:0]                          master_vol,
    output logic signed [OUTPUT_BITS-1:0]       dout,
    output logic                                dout_valid,
    output logic                                busy,
    output logic                                clip,
    output logic                                overrun
);

    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int PROD_W = DATA_BITS + GAIN_BITS + 1;
    localparam int ACC_W  = DATA_BITS + GAIN_BITS + 1 + $clog2(NUM_VOICES);
    localparam int FULL_W = ACC_W + 9;
    localparam int SHIFT  = GAIN_BITS + 8;

    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [FULL_W-1:0] OUT_MAX  = FULL_W'((64'sd1 <<< (OUTPUT_BITS - 1)) - 64'sd1);
    localparam logic signed [FULL_W-1:0] OUT_MIN  = ~OUT_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic signed [OUTPUT_BITS-1:0]   dout_q, dout_d;
    logic                            valid_q, valid_d;
    logic                            clip_q, clip_d;
    logic                            overrun_q, overrun_d;
    logic                            load;

    logic [NUM_VOICES*DATA_BITS-1:0] data_q;
    logic [NUM_VOICES*GAIN_BITS-1:0] gain_q;
    logic [7:0]                      vol_q;
    logic signed [FULL_W-1:0]        res_q;

    logic signed [DATA_BITS-1:0]     cur_voice;
    logic [GAIN_BITS-1:0]            cur_gain;
    logic signed [PROD_W-1:0]        prod;
    logic signed [FULL_W-1:0]        full;
    logic signed [FULL_W-1:0]        scaled;

    function automatic logic out_of_range(input logic signed [FULL_W-1:0] r);
        return (r > OUT_MAX) || (r < OUT_MIN);
    endfunction

    function automatic logic signed [OUTPUT_BITS-1:0] fit_output(input logic signed [FULL_W-1:0] r);
`ifdef VOICE_MIXER_SATURATE_EN
        if (r > OUT_MAX)
            return OUT_MAX[OUTPUT_BITS-1:0];
        else if (r < OUT_MIN)
            return OUT_MIN[OUTPUT_BITS-1:0];
        else
            return r[OUTPUT_BITS-1:0];
`else
        return r[OUTPUT_BITS-1:0];
`endif
    endfunction

    assign busy       = (state_q != IDLE) || valid_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign clip       = clip_q;
    assign overrun    = overrun_q;

    // Accumulate stage: pick the snapshotted voice/gain addressed by idx
    always_comb begin
        cur_voice = '0;
        cur_gain  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_voice = data_q[i*DATA_BITS +: DATA_BITS];
                cur_gain  = gain_q[i*GAIN_BITS +: GAIN_BITS];
            end
        end
    end

    assign prod   = PROD_W'(cur_voice) * PROD_W'($signed({1'b0, cur_gain}));

    // Scale stage: master volume then floor shift back to sample scale
    assign full   = FULL_W'(acc_q) * FULL_W'($signed({1'b0, vol_q}));
    assign scaled = full >>> SHIFT;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        clip_d    = clip_q;
        overrun_d = sample_tick && busy;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_tick && !busy) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + ACC_W'(prod);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX)
                    state_d = SCALE;
            end
            SCALE: begin
                state_d = OUT;
            end
            OUT: begin
                dout_d  = fit_output(res_q);
                clip_d  = out_of_range(res_q);
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            clip_q    <= clip_d;
            overrun_q <= overrun_d;
        end
    end

    // Snapshot and scaled result are pure data; only meaningful once control says so
    always_ff @(posedge main_clk) begin
        if (load) begin
            data_q <= voice_data;
            gain_q <= voice_gain;
            vol_q  <= master_vol;
        end
        if (state_q == SCALE)
            res_q <= scaled;
    end

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL provide parameter NUM_VOICES, default 4, number of voice inputs mixed (1..8).
REQ-002 SHALL provide parameter DATA_BITS, default 12, width of each signed voice sample.
REQ-003 SHALL provide parameter GAIN_BITS, default 4, width of each unsigned per-voice gain.
REQ-004 SHALL provide parameter OUTPUT_BITS, default 12, width of signed mixed output.
REQ-005 SHALL provide main_clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL provide rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL provide sample_tick  input  1  one-cycle pulse per audio sample period.
REQ-008 SHALL provide voice_data  input  NUM_VOICES*DATA_BITS  packed signed samples, voice i at [i*DATA_BITS +: DATA_BITS].
REQ-009 SHALL provide voice_gain  input  NUM_VOICES*GAIN_BITS  packed unsigned gains, voice i at [i*GAIN_BITS +: GAIN_BITS].
REQ-010 SHALL provide master_vol  input  8  unsigned master volume.
REQ-011 SHALL provide dout  output  OUTPUT_BITS  signed mixed sample, held between updates.
REQ-012 SHALL provide dout_valid  output  1  one-cycle pulse when dout updates.
REQ-013 SHALL provide busy  output  1  high while a mix is in progress.
REQ-014 SHALL provide clip  output  1  high with dout_valid when result exceeded output range; held until next update.
REQ-015 SHALL provide overrun  output  1  one-cycle pulse when sample_tick arrives while busy.

Function
REQ-016 SHALL implement states IDLE, ACCUM, SCALE, OUT; IDLE->ACCUM on sample_tick, ACCUM->SCALE after NUM_VOICES cycles, SCALE->OUT, OUT->IDLE.
REQ-017 SHALL, on sample_tick in IDLE, snapshot voice_data, voice_gain, master_vol, clear accumulator, set index 0.
REQ-018 SHALL in ACCUM add sext(voice[idx]) * zext(gain[idx]) to accumulator per cycle, idx incrementing 0..NUM_VOICES-1.
REQ-019 SHALL size accumulator DATA_BITS+GAIN_BITS+1+clog2(NUM_VOICES) bits signed; no accumulator overflow possible.
REQ-020 SHALL in SCALE compute full = acc * zext(master_vol), then result = full >>> (GAIN_BITS+8) (arithmetic, floor).
REQ-021 SHALL in OUT register dout from result (per REQ-029), pulse dout_valid, update clip.
REQ-022 SHALL produce dout_valid exactly NUM_VOICES+3 cycles after the sample_tick cycle (default 7).
REQ-023 SHALL assert busy from the cycle after accepted sample_tick through the dout_valid cycle inclusive.
REQ-024 SHALL ignore sample_tick while busy (no restart, snapshot unchanged) and pulse overrun next cycle.
REQ-025 SHALL accept a sample_tick coincident with the dout_valid cycle as overrun; a tick the following cycle is accepted.
REQ-026 SHALL ignore input changes after the snapshot cycle until the next accepted tick.

Reset
REQ-027 SHALL on rst low immediately force IDLE, dout=0, dout_valid=0, busy=0, clip=0, overrun=0, accumulator=0, idx=0.
REQ-028 SHALL abort any mix in progress on reset with no dout_valid; first tick after release starts a fresh mix.

Configuration
REQ-029 SHALL, with macro VOICE_MIXER_SATURATE_EN defined, clamp result to [-2^(OUTPUT_BITS-1), 2^(OUTPUT_BITS-1)-1]; without it, dout = low OUTPUT_BITS of result (wrap).
REQ-030 SHALL set clip whenever result is out of range, in both configurations.

Verification (defaults)
REQ-031 SHALL cover: voice0=1024, gain0=15, others gain 0, vol=255, tick -> after 7 cycles dout=956, clip=0.
REQ-032 SHALL cover: voice0=-1024, same gains/vol -> dout=-957, clip=0.
REQ-033 SHALL cover: all voices 2047, all gains 15, vol=255 -> with VOICE_MIXER_SATURATE_EN dout=2047, clip=1; without, dout=-546, clip=1.
REQ-034 SHALL cover: second tick 3 cycles after first -> overrun pulse, single dout_valid at cycle 7, busy high cycles 1..7.
REQ-035 SHALL cover: rst low at cycle 3 of a mix -> no dout_valid, all outputs 0; next tick yields correct dout 7 cycles later.
REQ-036 SHALL cover: vol=0 or all gains 0 with nonzero voices -> dout=0, clip=0.
